image_spike_encoder: RTL and testbench

IMAGE_SPIKE_ENCODER -- requirements
Module: image_spike_encoder

---
 rtl/image_spike_encoder.sv | 126 ++++++++++++
 tb/tb_image_spike_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_spike_encoder.sv
// Pixel-store spike encoder: walks the image and emits one spike per qualifying pixel.
// Optional macro RANK_ORDER_EN selects rank-order (brightest first) encoding; default is threshold mode.
module image_spike_encoder #(
  parameter int NPIX      = 256,
  parameter int PIX_W     = 8,
  parameter int THRESHOLD = 128
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             MEM_REN,
  output logic [7:0]       MEM_RADDR,
  input  logic [PIX_W-1:0] MEM_RDATA,
  output logic             SPIKE_VALID,
  output logic [7:0]       SPIKE_ADDR,
  input  logic             SPIKE_READY,
  output logic [8:0]       SPIKE_COUNT
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [8:0] cnt_q, cnt_d;
  logic       match, last_idx, last_pass, adv;

`ifdef RANK_ORDER_EN
  logic [PIX_W-1:0] level_q, level_d;

  // One pass per level from full scale down to 1; level never reaches 0, so dark pixels never match.
  always_comb begin
    match     = (MEM_RDATA == level_q) && (MEM_RDATA != '0);
    last_pass = (level_q == PIX_W'(1));
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) level_q <= '0;
    else          level_q <= level_d;
  end
`else
  localparam logic [31:0] THR_EFF = (THRESHOLD == 0) ? 32'd1 : 32'(THRESHOLD);

  always_comb begin
    match     = (32'(MEM_RDATA) >= THR_EFF) && (MEM_RDATA != '0);
    last_pass = 1'b1;
  end
`endif

  assign last_idx = (idx_q == 8'(NPIX-1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
`ifdef RANK_ORDER_EN
    level_d = level_q;
`endif
    case (state_q)
      S_IDLE: if (START) begin
        state_d = S_FETCH;
        idx_d   = '0;
        cnt_d   = '0;
`ifdef RANK_ORDER_EN
        level_d = '1;
`endif
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (match) state_d = S_EMIT;
        else       adv     = 1'b1;
      end
      S_EMIT: if (SPIKE_READY) begin
        cnt_d = cnt_q + 9'd1;
        adv   = 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Shared advance step for both the no-match and the post-handshake paths.
    if (adv) begin
      if (last_idx) begin
        idx_d = '0;
        if (last_pass) state_d = S_FINISH;
        else begin
          state_d = S_FETCH;
`ifdef RANK_ORDER_EN
          level_d = level_q - PIX_W'(1);
`endif
        end
      end else begin
        idx_d   = idx_q + 8'd1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // FINISH is excluded so BUSY falls in the same cycle DONE pulses.
  assign BUSY        = (state_q == S_FETCH) || (state_q == S_CHECK) || (state_q == S_EMIT);
  assign DONE        = (state_q == S_FINISH);
  assign MEM_REN     = (state_q == S_FETCH);
  assign MEM_RADDR   = idx_q;
  assign SPIKE_VALID = (state_q == S_EMIT);
  assign SPIKE_ADDR  = idx_q;
  assign SPIKE_COUNT = cnt_q;

endmodule

// File: tb/tb_image_spike_encoder.sv
// Self-checking bench for image_spike_encoder: vector table, hand-written corner sequences, random images.
`timescale 1ns/1ps
module tb_image_spike_encoder;
`ifdef RANK_ORDER_EN
  localparam int NPIX   = 16;
  localparam int PASSES = 255;
  localparam int NRAND  = 2;
`else
  localparam int NPIX   = 256;
  localparam int PASSES = 1;
  localparam int NRAND  = 6;
`endif
  localparam int THR  = 128;
  localparam int MAXC = 4 * 2 * NPIX * PASSES + 2000;

  logic       ACLK = 1'b0;
  logic       ARESETN, START, SPIKE_READY;
  logic       BUSY, DONE, MEM_REN, SPIKE_VALID;
  logic [7:0] MEM_RADDR, SPIKE_ADDR, MEM_RDATA;
  logic [8:0] SPIKE_COUNT;

  image_spike_encoder #(.NPIX(NPIX), .PIX_W(8), .THRESHOLD(THR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .BUSY(BUSY), .DONE(DONE),
    .MEM_REN(MEM_REN), .MEM_RADDR(MEM_RADDR), .MEM_RDATA(MEM_RDATA),
    .SPIKE_VALID(SPIKE_VALID), .SPIKE_ADDR(SPIKE_ADDR), .SPIKE_READY(SPIKE_READY),
    .SPIKE_COUNT(SPIKE_COUNT)
  );

  always #5 ACLK = ~ACLK;

  logic [7:0] pix [0:255];
  int got[$], exp_q[$];
  int exp_cyc, done_cnt, busy_cyc, stall_err, proto_err, n_pass, n_tot, rdy_mode;
  logic pv, pr;
  logic [7:0] pa;

  // One-cycle-latency pixel store
  always @(posedge ACLK) if (MEM_REN) MEM_RDATA <= pix[MEM_RADDR];

  always @(posedge ACLK) begin
    #1;
    case (rdy_mode)
      0:       SPIKE_READY = 1'b0;
      1:       SPIKE_READY = 1'b1;
      default: SPIKE_READY = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: record handshakes, pulses, busy cycles and protocol violations mid-cycle.
  always @(negedge ACLK) begin
    if (!ARESETN) pv = 1'b0;
    else begin
      if (SPIKE_VALID && SPIKE_READY) got.push_back(int'(SPIKE_ADDR));
      if (DONE) done_cnt++;
      if (BUSY) busy_cyc++;
      if (DONE && BUSY) proto_err++;
      if (pv && !pr && (!SPIKE_VALID || SPIKE_ADDR != pa)) stall_err++;
      pv = SPIKE_VALID; pr = SPIKE_READY; pa = SPIKE_ADDR;
    end
  end

  function automatic void chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // Reference: spike order derived directly from the encoding rules.
  function automatic void build_exp();
    exp_q.delete();
`ifdef RANK_ORDER_EN
    for (int lv = 255; lv >= 1; lv--)
      for (int i = 0; i < NPIX; i++)
        if (int'(pix[i]) == lv) exp_q.push_back(i);
`else
    for (int i = 0; i < NPIX; i++)
      if (pix[i] != 0 && int'(pix[i]) >= ((THR == 0) ? 1 : THR)) exp_q.push_back(i);
`endif
    exp_cyc = 2 * NPIX * PASSES + exp_q.size();
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) pix[i] = 8'd0;
  endtask

  task automatic do_reset();
    @(posedge ACLK); #1 ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  task automatic launch();
    got.delete(); done_cnt = 0; busy_cyc = 0;
    @(posedge ACLK); #1 START = 1'b1;
    @(posedge ACLK); #1 START = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    bit ok = 0;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge ACLK);
      if (SPIKE_VALID) begin ok = 1; break; end
    end
    chk({nm, " valid seen"}, int'(ok), 1);
  endtask

  task automatic finish_check(input string nm, input bit timing);
    bit ok = 0;
    int mism = 0;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge ACLK);
      if (DONE) begin ok = 1; break; end
    end
    chk({nm, " done seen"}, int'(ok), 1);
    if (!ok) do_reset();
    repeat (2) @(negedge ACLK);
    build_exp();
    chk({nm, " done pulses"}, done_cnt, 1);
    chk({nm, " spike_count"}, int'(SPIKE_COUNT), exp_q.size());
    chk({nm, " accepted"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] != exp_q[i]) mism++;
    chk({nm, " order"}, mism, 0);
    if (timing) chk({nm, " busy cycles"}, busy_cyc, exp_cyc);
  endtask

  typedef struct {
    string nm;
    int ia, va, ib, vb, ic, vc;
    int exp_n, exp_f, exp_l;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int bad;
    n_pass = 0; n_tot = 0; stall_err = 0; proto_err = 0;
    done_cnt = 0; busy_cyc = 0; pv = 1'b0; pr = 1'b0; pa = '0;
    ARESETN = 1'b0; START = 1'b0; rdy_mode = 1;
    clear_img();

`ifdef RANK_ORDER_EN
    tbl.push_back('{"rank3",  3, 10,  9, 250,  1, 250, 3, 1, 3});
    tbl.push_back('{"zero",  -1,  0, -1,   0, -1,   0, 0, -1, -1});
    tbl.push_back('{"ones",   0,  1, 15,   1,  7,   2, 3, 7, 15});
`else
    tbl.push_back('{"zero",  -1,   0, -1,   0,  -1,   0, 0, -1, -1});
    tbl.push_back('{"one",    5, 200,  7, 127,  -1,   0, 1,  5,  5});
    tbl.push_back('{"edges",  0, 128, 255, 255, 100, 127, 2,  0, 255});
    tbl.push_back('{"dim",    1,   1,  2, 127,   3,   0, 0, -1, -1});
    tbl.push_back('{"three",  4, 255,  2, 129,   9, 130, 3,  2,  9});
`endif

    repeat (2) @(negedge ACLK);
    chk("reset outputs", int'({BUSY, DONE, MEM_REN, SPIKE_VALID, MEM_RADDR, SPIKE_ADDR, SPIKE_COUNT}), 0);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    @(negedge ACLK);
    chk("idle after reset", int'({BUSY, DONE, SPIKE_VALID, SPIKE_COUNT}), 0);

    foreach (tbl[k]) begin
      clear_img();
      if (tbl[k].ia >= 0) pix[tbl[k].ia] = 8'(tbl[k].va);
      if (tbl[k].ib >= 0) pix[tbl[k].ib] = 8'(tbl[k].vb);
      if (tbl[k].ic >= 0) pix[tbl[k].ic] = 8'(tbl[k].vc);
      rdy_mode = 1;
      launch();
      finish_check(tbl[k].nm, 1'b1);
      chk({tbl[k].nm, " tbl count"}, got.size(), tbl[k].exp_n);
      chk({tbl[k].nm, " tbl first"}, (got.size() > 0) ? got[0] : -1, tbl[k].exp_f);
      chk({tbl[k].nm, " tbl last"}, (got.size() > 0) ? got[got.size()-1] : -1, tbl[k].exp_l);
    end

    // Backpressure: hold the spike for 20 cycles, then release.
    clear_img(); pix[5] = 8'd200;
    rdy_mode = 0;
    launch();
    wait_valid("bp");
    bad = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (!SPIKE_VALID || SPIKE_ADDR != 8'd5 || SPIKE_COUNT != 9'd0) bad++;
    end
    chk("bp stable", bad, 0);
    rdy_mode = 1;
    finish_check("bp", 1'b0);

    // Abort mid-pass with a spike pending, then re-encode from scratch.
    clear_img(); pix[5] = 8'd200; pix[9] = 8'd200;
    rdy_mode = 0;
    launch();
    wait_valid("abort");
    @(posedge ACLK); #1 ARESETN = 1'b0;
    #1 chk("abort outputs", int'({BUSY, DONE, MEM_REN, SPIKE_VALID, MEM_RADDR, SPIKE_ADDR, SPIKE_COUNT}), 0);
    repeat (3) @(negedge ACLK);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    repeat (2 * NPIX * PASSES + 10) @(negedge ACLK);
    chk("abort no done", done_cnt, 0);
    rdy_mode = 1;
    launch();
    finish_check("restart", 1'b1);

    // START pulses while busy must be ignored.
    clear_img(); pix[2] = 8'd250; pix[NPIX-1] = 8'd180; pix[8] = 8'd200;
    rdy_mode = 2;
    launch();
    repeat (5) begin
      repeat (37) @(posedge ACLK);
      #1 START = 1'b1;
      @(posedge ACLK); #1 START = 1'b0;
    end
    finish_check("restart_ignored", 1'b0);

    for (int r = 0; r < NRAND; r++) begin
      for (int i = 0; i < 256; i++)
        pix[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      pix[0] = 8'(THR); pix[NPIX-1] = 8'(THR - 1);
      rdy_mode = (r % 2 == 0) ? 2 : 1;
      launch();
      finish_check($sformatf("rand%0d", r), rdy_mode == 1);
    end

    chk("stall violations", stall_err, 0);
    chk("busy during done", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
